// File: rtl/stack_access_unit.sv
// Memory-stage stack datapath: turns stack-sequencer steps and single PUSH/POP
// into 16-bit stack memory accesses, owns SP, and reassembles popped PC/flags.
module stack_access_unit #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned SP_INIT = 2047,
  parameter int unsigned FLAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        sm_state,
  input  logic [1:0]        sm_mode,
  input  logic [31:0]       pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              stack_push,
  input  logic              stack_pop,
  input  logic [15:0]       push_data,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       pc_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic              restore_valid,
  output logic [15:0]       pop_data,
  output logic              pop_valid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_wrap
);

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_FLAGS, SEQ_NOFLAGS} seq_t;
  typedef enum logic [1:0] {CAP_PC_LO, CAP_PC_HI, CAP_FLAGS, CAP_POP} cap_t;

  seq_t seq_q, seq_d;

  logic              step_ok;
  logic [15:0]       seq_word;
  cap_t              seq_cap;
  logic              seq_last;
  logic              seq_push, seq_pop, single_ok, do_push, do_pop;
  logic [ADDR_W-1:0] sp_q, sp_inc;

  logic              pend_v, pend_last;
  cap_t              pend_kind;
  logic [15:0]       pc_lo_q, pc_hi_q;

  // Sequence tracker: remembers whether the running sequence carries flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= SEQ_IDLE;
    else        seq_q <= seq_d;
  end

  always_comb begin
    seq_d = seq_q;
    case (sm_state)
      2'b11:   seq_d = SEQ_FLAGS;
      2'b10:   seq_d = (seq_q == SEQ_FLAGS) ? SEQ_FLAGS : SEQ_NOFLAGS;
      default: seq_d = SEQ_IDLE;
    endcase
  end

  // Step decode; state 01 is only honoured inside a sequence that was entered at 11/10.
  always_comb begin
    step_ok  = 1'b0;
    seq_word = '0;
    seq_cap  = CAP_PC_LO;
    seq_last = 1'b0;
    case (sm_state)
      2'b11: begin
        step_ok  = 1'b1;
        seq_word = 16'(flags_in);
        seq_cap  = CAP_PC_LO;
      end
      2'b10: begin
        step_ok  = 1'b1;
        seq_word = pc_in[31:16];
        seq_cap  = (seq_q == SEQ_FLAGS) ? CAP_PC_HI : CAP_PC_LO;
      end
      2'b01: begin
        step_ok  = (seq_q != SEQ_IDLE);
        seq_word = pc_in[15:0];
        seq_cap  = (seq_q == SEQ_FLAGS) ? CAP_FLAGS : CAP_PC_HI;
        seq_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign seq_push  = step_ok && (sm_mode == 2'b10);
  assign seq_pop   = step_ok && (sm_mode == 2'b11);
  assign single_ok = (sm_state == 2'b00) && (stack_push ^ stack_pop);
  assign do_push   = seq_push || (single_ok && stack_push);
  assign do_pop    = seq_pop  || (single_ok && stack_pop);
  assign sp_inc    = sp_q + ADDR_W'(1);

  assign mem_we    = rst_n && do_push;
  assign mem_re    = rst_n && do_pop;
  assign mem_addr  = do_pop ? sp_inc : sp_q;
  assign mem_wdata = !do_push ? '0 : (seq_push ? seq_word : push_data);
  assign sp_out    = sp_q;

  // Read data arrives one cycle after mem_re, so each read leaves a one-deep
  // pending tag that is resolved against mem_rdata on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q          <= ADDR_W'(SP_INIT);
      sp_wrap       <= 1'b0;
      pend_v        <= 1'b0;
      pend_last     <= 1'b0;
      pend_kind     <= CAP_POP;
      pc_lo_q       <= '0;
      pc_hi_q       <= '0;
      pc_out        <= '0;
      flags_out     <= '0;
      restore_valid <= 1'b0;
      pop_data      <= '0;
      pop_valid     <= 1'b0;
    end else begin
      restore_valid <= 1'b0;
      pop_valid     <= 1'b0;

      if (do_push) begin
        sp_q <= sp_q - ADDR_W'(1);
        if (sp_q == '0) sp_wrap <= 1'b1;
      end else if (do_pop) begin
        sp_q <= sp_inc;
        if (sp_q == '1) sp_wrap <= 1'b1;
      end

      pend_v    <= do_pop;
      pend_kind <= seq_pop ? seq_cap : CAP_POP;
      pend_last <= seq_pop && seq_last;

      if (pend_v) begin
        case (pend_kind)
          CAP_PC_LO: pc_lo_q <= mem_rdata;
          CAP_PC_HI: pc_hi_q <= mem_rdata;
          CAP_FLAGS: ;
          CAP_POP: begin
            pop_data  <= mem_rdata;
            pop_valid <= 1'b1;
          end
          default: ;
        endcase
        if (pend_last) begin
          restore_valid <= 1'b1;
          if (pend_kind == CAP_FLAGS) begin
            pc_out    <= {pc_hi_q, pc_lo_q};
            flags_out <= mem_rdata[FLAG_W-1:0];
          end else begin
            pc_out <= {mem_rdata, pc_lo_q};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_access_unit.sv
// Randomised bench for stack_access_unit: a word-level stack model predicts every
// access and restored value; one negedge process compares the DUT against it.
`timescale 1ns/1ps
module tb_stack_access_unit;

  localparam int DEPTH = 2048;
  localparam int SPI   = 2047;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sm_state, sm_mode;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic        stack_push, stack_pop;
  logic [15:0] push_data, mem_rdata;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
  logic        restore_valid;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [10:0] sp_out;
  logic        sp_wrap;

  always #5 clk = ~clk;

  stack_access_unit #(.ADDR_W(11), .SP_INIT(2047), .FLAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sm_state(sm_state), .sm_mode(sm_mode),
    .pc_in(pc_in), .flags_in(flags_in), .stack_push(stack_push),
    .stack_pop(stack_pop), .push_data(push_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .pc_out(pc_out), .flags_out(flags_out), .restore_valid(restore_valid),
    .pop_data(pop_data), .pop_valid(pop_valid), .sp_out(sp_out), .sp_wrap(sp_wrap)
  );

  // Synchronous stack memory seen by the DUT.
  logic [15:0] envmem [DEPTH];
  logic        clr_mem;
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < DEPTH; i++) envmem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) envmem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= envmem[mem_addr];
    end
  end

  // Reference model: abstract stack contents, SP and scheduled registered results.
  logic [15:0] m_mem [DEPTH];
  int unsigned m_sp;
  bit          m_wrap;
  int          cyc = 0;

  typedef struct {
    int          due;
    bit          is_restore;
    logic [31:0] pc;
    bit          has_fl;
    logic [2:0]  fl;
    logic [15:0] d;
  } ev_t;
  ev_t evq[$];

  bit          x_we, x_re, x_rv, x_pv, x_wrap;
  logic [10:0] x_addr, x_sp;
  logic [15:0] x_wdata, x_pd;
  logic [31:0] x_pc;
  logic [2:0]  x_fl;

  // Hand-computed literal expectations, consumed by the compare process.
  string       pin_nm   [256];
  int          pin_sel  [256];
  int          pin_adr  [256];
  logic [31:0] pin_val  [256];
  int          pin_wr = 0;
  int          pin_rd = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] a;
    chk("mem_we", 32'(mem_we), 32'(x_we));
    chk("mem_re", 32'(mem_re), 32'(x_re));
    if (x_we || x_re) chk("mem_addr", 32'(mem_addr), 32'(x_addr));
    if (x_we) chk("mem_wdata", 32'(mem_wdata), 32'(x_wdata));
    chk("pc_out", pc_out, x_pc);
    chk("flags_out", 32'(flags_out), 32'(x_fl));
    chk("restore_valid", 32'(restore_valid), 32'(x_rv));
    chk("pop_data", 32'(pop_data), 32'(x_pd));
    chk("pop_valid", 32'(pop_valid), 32'(x_pv));
    chk("sp_out", 32'(sp_out), 32'(x_sp));
    chk("sp_wrap", 32'(sp_wrap), 32'(x_wrap));
    while (pin_rd < pin_wr) begin
      case (pin_sel[pin_rd])
        0:       a = 32'(sp_out);
        1:       a = pc_out;
        2:       a = 32'(flags_out);
        3:       a = 32'(pop_data);
        4:       a = 32'(sp_wrap);
        5:       a = 32'(envmem[pin_adr[pin_rd]]);
        6:       a = 32'(mem_we);
        7:       a = 32'(restore_valid);
        8:       a = 32'(pop_valid);
        default: a = 'x;
      endcase
      chk(pin_nm[pin_rd], a, pin_val[pin_rd]);
      pin_rd++;
    end
  end

  task automatic pin(input string nm, input int sel, input logic [31:0] v, input int adr = 0);
    pin_nm[pin_wr]  = nm;
    pin_sel[pin_wr] = sel;
    pin_val[pin_wr] = v;
    pin_adr[pin_wr] = adr;
    pin_wr++;
  endtask

  task automatic model_reset();
    m_sp   = SPI;
    m_wrap = 1'b0;
    evq.delete();
    x_we = 0; x_re = 0; x_addr = '0; x_wdata = '0;
    x_pc = '0; x_fl = '0; x_rv = 0; x_pd = '0; x_pv = 0;
    x_sp = 11'(SPI); x_wrap = 0;
  endtask

  task automatic idle_inputs();
    sm_state   = 2'b00;
    sm_mode    = 2'b00;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    pc_in      = $urandom;
    flags_in   = 3'($urandom);
    push_data  = 16'($urandom);
    x_we = 0; x_re = 0; x_addr = '0; x_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    x_sp   = 11'(m_sp);
    x_wrap = m_wrap;
    x_rv   = 0;
    x_pv   = 0;
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].due == cyc) begin
        if (evq[i].is_restore) begin
          x_pc = evq[i].pc;
          if (evq[i].has_fl) x_fl = evq[i].fl;
          x_rv = 1;
        end else begin
          x_pd = evq[i].d;
          x_pv = 1;
        end
        evq.delete(i);
      end
    end
    idle_inputs();
  endtask

  task automatic m_write(input logic [15:0] w);
    x_we = 1; x_addr = 11'(m_sp); x_wdata = w;
    m_mem[m_sp] = w;
    if (m_sp == 0) begin m_sp = DEPTH - 1; m_wrap = 1; end
    else m_sp = m_sp - 1;
  endtask

  task automatic m_read(output logic [15:0] w);
    int unsigned a;
    a = (m_sp + 1) % DEPTH;
    x_re = 1; x_addr = 11'(a);
    w = m_mem[a];
    if (a == 0) m_wrap = 1;
    m_sp = a;
  endtask

  task automatic noise(input bit en);
    if (en) begin
      stack_push = 1'($urandom);
      stack_pop  = 1'($urandom);
    end
  endtask

  task automatic push_seq(input bit wf, input logic [31:0] pc, input logic [2:0] fl, input bit nz);
    logic [15:0] words[$];
    if (wf) words.push_back({13'd0, fl});
    words.push_back(pc[31:16]);
    words.push_back(pc[15:0]);
    foreach (words[i]) begin
      sm_state = wf ? 2'(3 - i) : 2'(2 - i);
      sm_mode  = 2'b10;
      pc_in    = pc;
      flags_in = fl;
      noise(nz);
      m_write(words[i]);
      tick();
    end
  endtask

  task automatic pop_seq(input bit wf, input bit nz);
    logic [15:0] w[3];
    int n;
    ev_t e;
    n = wf ? 3 : 2;
    w[2] = '0;
    for (int i = 0; i < n; i++) begin
      sm_state = wf ? 2'(3 - i) : 2'(2 - i);
      sm_mode  = 2'b11;
      noise(nz);
      m_read(w[i]);
      if (i == n - 1) begin
        e.due = cyc + 2; e.is_restore = 1; e.pc = {w[1], w[0]};
        e.has_fl = wf; e.fl = w[2][2:0]; e.d = '0;
        evq.push_back(e);
      end
      tick();
    end
  endtask

  task automatic single(input bit p, input bit q, input logic [15:0] d);
    logic [15:0] w;
    ev_t e;
    stack_push = p;
    stack_pop  = q;
    push_data  = d;
    if (p && !q) m_write(d);
    else if (q && !p) begin
      m_read(w);
      e.due = cyc + 2; e.is_restore = 0; e.pc = '0; e.has_fl = 0; e.fl = '0; e.d = w;
      evq.push_back(e);
    end
    tick();
  endtask

  // Sequence steps with mode 00: the sequencer is busy but nothing touches memory.
  task automatic quiet_seq(input bit wf, input bit nz);
    int n;
    n = wf ? 3 : 2;
    for (int i = 0; i < n; i++) begin
      sm_state = wf ? 2'(3 - i) : 2'(2 - i);
      sm_mode  = 2'b00;
      noise(nz);
      tick();
    end
  endtask

  task automatic mid_reset();
    logic [15:0] w;
    sm_state = 2'b11; sm_mode = 2'b11;
    m_read(w);
    tick();
    sm_state = 2'b10; sm_mode = 2'b11;
    m_read(w);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    clr_mem = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    idle_inputs();
    repeat (2) tick();
    rst_n   = 1'b1;
    clr_mem = 1'b0;
    tick();
    pin("lit_reset_sp", 0, 32'd2047);

    // Push with flags, then pop it back.
    push_seq(1, 32'h0012_3456, 3'b101, 0);
    pin("lit_w2047", 5, 32'h0005, 2047);
    pin("lit_w2046", 5, 32'h0012, 2046);
    pin("lit_w2045", 5, 32'h3456, 2045);
    pin("lit_sp_after_push", 0, 32'd2044);
    pop_seq(1, 0);
    tick();
    pin("lit_restore_pulse", 7, 32'd1);
    pin("lit_pc_flags", 1, 32'h0012_3456);
    pin("lit_flags", 2, 32'd5);
    pin("lit_sp_after_pop", 0, 32'd2047);

    // Without flags: flags_out keeps the earlier value.
    push_seq(0, 32'hABCD_0001, 3'b010, 0);
    pin("lit_sp_noflags", 0, 32'd2045);
    pop_seq(0, 0);
    tick();
    pin("lit_pc_noflags", 1, 32'hABCD_0001);
    pin("lit_flags_kept", 2, 32'd5);
    pin("lit_sp_back", 0, 32'd2047);

    // Single PUSH / POP.
    single(1, 0, 16'hBEEF);
    pin("lit_sp_push1", 0, 32'd2046);
    pin("lit_w_beef", 5, 32'hBEEF, 2047);
    single(0, 1, 16'h0);
    tick();
    pin("lit_pop_data", 3, 32'hBEEF);
    pin("lit_pop_valid", 8, 32'd1);

    // PUSH with POP, and PUSH while the sequencer is busy: both ignored.
    stack_push = 1; stack_pop = 1; push_data = 16'h5555;
    pin("lit_both_no_we", 6, 32'd0);
    tick();
    sm_state = 2'b10; sm_mode = 2'b00; stack_push = 1;
    pin("lit_busy_no_we", 6, 32'd0);
    tick();
    sm_state = 2'b01; sm_mode = 2'b00; stack_push = 1;
    tick();
    pin("lit_sp_unchanged", 0, 32'd2047);

    // Walk SP down to 0, then one more push wraps.
    for (int i = 0; i < 2047; i++) single(1, 0, 16'($urandom));
    pin("lit_sp_zero", 0, 32'd0);
    pin("lit_no_wrap_yet", 4, 32'd0);
    single(1, 0, 16'h1234);
    pin("lit_sp_wrapped", 0, 32'd2047);
    pin("lit_wrap_set", 4, 32'd1);
    pin("lit_w_addr0", 5, 32'h1234, 0);

    // Reset in the middle of a pop sequence.
    mid_reset();
    pin("lit_rst_sp", 0, 32'd2047);
    pin("lit_rst_wrap", 4, 32'd0);
    pin("lit_rst_pc", 1, 32'd0);
    pin("lit_rst_no_restore", 7, 32'd0);

    // Pop at the top of memory wraps upward.
    single(0, 1, 16'h0);
    pin("lit_sp_pop_wrap", 0, 32'd0);
    pin("lit_wrap_pop", 4, 32'd1);

    // Random mix, including back-to-back sequences and ignored requests.
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      bit nz;
      r  = $urandom_range(0, 9);
      nz = 1'($urandom);
      case (r)
        0: push_seq(1, $urandom, 3'($urandom), nz);
        1: push_seq(0, $urandom, 3'($urandom), nz);
        2: pop_seq(1, nz);
        3: pop_seq(0, nz);
        4: single(1, 0, 16'($urandom));
        5: single(0, 1, 16'($urandom));
        6: single(1, 1, 16'($urandom));
        7: begin
          sm_state   = 2'b01;
          sm_mode    = $urandom_range(0, 1) ? 2'b10 : 2'b11;
          stack_push = 1'($urandom);
          tick();
        end
        8: quiet_seq(1'($urandom), nz);
        default: tick();
      endcase
    end

    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
